// File: rtl/mem_stage.sv
// Memory-access stage: drives a req/ready/rvalid data port, stalls upstream until the access
// completes, lane-aligns stores and loads, and registers the MEM/WB result.
// Optional build macro: MEM_STAGE_MISALIGN_TRAP_EN (misaligned word/halfword accesses raise o_err).
module mem_stage #(
    parameter int MAX_WAIT = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_result,
    input  logic [31:0] i_mem_addr,
    input  logic [3:0]  i_mask,
    input  logic        i_unsigned,
    input  logic [31:0] i_store_data,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic        i_MemtoReg,
    input  logic        i_RegWrite,
    input  logic [4:0]  i_rd_waddr,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic [31:0] o_dmem_addr,
    output logic        o_dmem_wen,
    output logic [3:0]  o_dmem_mask,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_valid,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_rd_waddr,
    output logic        o_RegWrite,
    output logic        o_err
);

    // The counter only needs to reach MAX_WAIT-1; keep at least one bit when the timeout is off.
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] wait_cnt_reg;

    logic [31:0] addr_reg;
    logic [3:0]  mask_reg;
    logic [31:0] wdata_reg;
    logic        wen_reg;
    logic [31:0] result_reg;
    logic        unsigned_reg;
    logic        memtoreg_reg;
    logic        regwrite_reg;
    logic [4:0]  rd_reg;

    logic        mem_op;
    logic        mask_legal;
    logic        byte_mode;
    logic        half_mode;
    logic        start_access;
    logic        in_req;
    logic        in_wait;
    logic        rsp_done;
    logic        timeout_hit;
    logic [31:0] wdata_lane;
    logic [31:0] load_val;
    logic [31:0] byte_ext [4];

    assign mem_op = i_valid && (i_MemRead || i_MemWrite);

    always_comb begin
        mask_legal = 1'b0;
        byte_mode  = 1'b0;
        half_mode  = 1'b0;
        case (i_mask)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                mask_legal = 1'b1;
                byte_mode  = 1'b1;
            end
            4'b0011, 4'b1100: begin
                half_mode = 1'b1;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                mask_legal = !i_result[0];
`else
                mask_legal = 1'b1;
`endif
            end
            4'b1111: begin
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                mask_legal = (i_result[1:0] == 2'b00);
`else
                mask_legal = 1'b1;
`endif
            end
            default: mask_legal = 1'b0;
        endcase
    end

    // Store replication: each lane takes the byte/half it would hold if the access landed there.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
            assign wdata_lane[8*gi +: 8] = byte_mode ? i_store_data[7:0] :
                                           half_mode ? i_store_data[8*(gi%2) +: 8] :
                                                       i_store_data[8*gi +: 8];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_load_lane
            assign byte_ext[gi] = {{24{!unsigned_reg && i_dmem_rdata[8*gi+7]}},
                                   i_dmem_rdata[8*gi +: 8]};
        end
    endgenerate

    always_comb begin
        load_val = i_dmem_rdata;
        case (mask_reg)
            4'b0001: load_val = byte_ext[0];
            4'b0010: load_val = byte_ext[1];
            4'b0100: load_val = byte_ext[2];
            4'b1000: load_val = byte_ext[3];
            4'b0011: load_val = {{16{!unsigned_reg && i_dmem_rdata[15]}}, i_dmem_rdata[15:0]};
            4'b1100: load_val = {{16{!unsigned_reg && i_dmem_rdata[31]}}, i_dmem_rdata[31:16]};
            default: load_val = i_dmem_rdata;
        endcase
    end

    assign in_req       = (state_reg == REQ);
    assign in_wait      = (state_reg == WAIT);
    assign start_access = !i_rst && (state_reg == IDLE) && mem_op && mask_legal;
    assign rsp_done     = in_wait && i_dmem_rvalid;
    assign timeout_hit  = (MAX_WAIT > 0) && (wait_cnt_reg == CNT_LAST);

    // Request fields come live from execute in IDLE and from the captured copies afterwards.
    assign o_dmem_req   = start_access || (!i_rst && in_req);
    assign o_dmem_addr  = (state_reg == IDLE) ? i_mem_addr : addr_reg;
    assign o_dmem_mask  = (state_reg == IDLE) ? i_mask     : mask_reg;
    assign o_dmem_wdata = (state_reg == IDLE) ? wdata_lane : wdata_reg;
    assign o_dmem_wen   = (state_reg == IDLE) ? i_MemWrite : wen_reg;

    // Stall drops in the completing cycle so upstream advances on the same edge we register.
    assign o_stall = !i_rst &&
                     (start_access || in_req || (in_wait && !rsp_done && !timeout_hit));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            o_valid      <= 1'b0;
            o_RegWrite   <= 1'b0;
            o_err        <= 1'b0;
            o_wb_data    <= '0;
            o_rd_waddr   <= '0;
            addr_reg     <= '0;
            mask_reg     <= '0;
            wdata_reg    <= '0;
            wen_reg      <= 1'b0;
            result_reg   <= '0;
            unsigned_reg <= 1'b0;
            memtoreg_reg <= 1'b0;
            regwrite_reg <= 1'b0;
            rd_reg       <= '0;
        end else begin
            o_valid    <= 1'b0;
            o_RegWrite <= 1'b0;
            o_err      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_access) begin
                        addr_reg     <= i_mem_addr;
                        mask_reg     <= i_mask;
                        wdata_reg    <= wdata_lane;
                        wen_reg      <= i_MemWrite;
                        result_reg   <= i_result;
                        unsigned_reg <= i_unsigned;
                        memtoreg_reg <= i_MemtoReg;
                        regwrite_reg <= i_RegWrite;
                        rd_reg       <= i_rd_waddr;
                        wait_cnt_reg <= '0;
                        state_reg    <= i_dmem_ready ? WAIT : REQ;
                    end else if (i_valid) begin
                        o_valid    <= 1'b1;
                        o_rd_waddr <= i_rd_waddr;
                        if (mem_op) begin
                            // Rejected mask or misalignment: no bus cycle, flag the error.
                            o_err     <= 1'b1;
                            o_wb_data <= '0;
                        end else begin
                            o_wb_data  <= i_result;
                            o_RegWrite <= i_RegWrite;
                        end
                    end
                end
                REQ: begin
                    if (i_dmem_ready) begin
                        wait_cnt_reg <= '0;
                        state_reg    <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_dmem_rvalid) begin
                        o_valid    <= 1'b1;
                        o_rd_waddr <= rd_reg;
                        o_wb_data  <= memtoreg_reg ? load_val : result_reg;
                        o_RegWrite <= regwrite_reg && !wen_reg;
                        state_reg  <= IDLE;
                    end else if (timeout_hit) begin
                        o_valid    <= 1'b1;
                        o_err      <= 1'b1;
                        o_rd_waddr <= rd_reg;
                        o_wb_data  <= '0;
                        state_reg  <= IDLE;
                    end else if (MAX_WAIT > 0) begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: per-scenario tasks with inline checks plus a
// completion scoreboard fed when stimulus is driven and drained as o_valid appears.
module tb_mem_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [31:0] i_result;
    logic [31:0] i_mem_addr;
    logic [3:0]  i_mask;
    logic        i_unsigned;
    logic [31:0] i_store_data;
    logic        i_MemRead;
    logic        i_MemWrite;
    logic        i_MemtoReg;
    logic        i_RegWrite;
    logic [4:0]  i_rd_waddr;
    logic        o_stall;
    logic        o_dmem_req;
    logic [31:0] o_dmem_addr;
    logic        o_dmem_wen;
    logic [3:0]  o_dmem_mask;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ready;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        o_valid;
    logic [31:0] o_wb_data;
    logic [4:0]  o_rd_waddr;
    logic        o_RegWrite;
    logic        o_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        rw;
        logic        err;
        logic        chk_wb;
    } exp_t;

    exp_t exp_q[$];

    always #5 i_clk = ~i_clk;

    mem_stage #(.MAX_WAIT(4)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .i_result      (i_result),
        .i_mem_addr    (i_mem_addr),
        .i_mask        (i_mask),
        .i_unsigned    (i_unsigned),
        .i_store_data  (i_store_data),
        .i_MemRead     (i_MemRead),
        .i_MemWrite    (i_MemWrite),
        .i_MemtoReg    (i_MemtoReg),
        .i_RegWrite    (i_RegWrite),
        .i_rd_waddr    (i_rd_waddr),
        .o_stall       (o_stall),
        .o_dmem_req    (o_dmem_req),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_wen    (o_dmem_wen),
        .o_dmem_mask   (o_dmem_mask),
        .o_dmem_wdata  (o_dmem_wdata),
        .i_dmem_ready  (i_dmem_ready),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata),
        .o_valid       (o_valid),
        .o_wb_data     (o_wb_data),
        .o_rd_waddr    (o_rd_waddr),
        .o_RegWrite    (o_RegWrite),
        .o_err         (o_err)
    );

    // Scoreboard: every registered completion must match the oldest expectation.
    always @(negedge i_clk) begin
        exp_t e;
        if (o_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got wb=%h rd=%0d with no expected entry", o_wb_data, o_rd_waddr);
            end else begin
                e = exp_q.pop_front();
                if (o_rd_waddr !== e.rd || o_RegWrite !== e.rw || o_err !== e.err ||
                    (e.chk_wb && o_wb_data !== e.wb)) begin
                    errors++;
                    $display("FAIL sb_completion: got wb=%h rd=%0d rw=%b err=%b, expected wb=%h rd=%0d rw=%b err=%b",
                             o_wb_data, o_rd_waddr, o_RegWrite, o_err, e.wb, e.rd, e.rw, e.err);
                end else begin
                    $display("txn wb=%h rd=%0d rw=%b err=%b", o_wb_data, o_rd_waddr, o_RegWrite, o_err);
                end
            end
        end
    end

    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic set_idle();
        i_valid = 0; i_result = '0; i_mem_addr = '0; i_mask = '0; i_unsigned = 0;
        i_store_data = '0; i_MemRead = 0; i_MemWrite = 0; i_MemtoReg = 0; i_RegWrite = 0;
        i_rd_waddr = '0; i_dmem_ready = 0; i_dmem_rvalid = 0; i_dmem_rdata = '0;
    endtask

    task automatic drive_mem(input logic is_store, input logic [31:0] res, input logic [3:0] m,
                             input logic uns, input logic [31:0] sd, input logic [4:0] rd);
        i_valid = 1; i_result = res; i_mem_addr = {res[31:2], 2'b00}; i_mask = m;
        i_unsigned = uns; i_store_data = sd; i_MemRead = !is_store; i_MemWrite = is_store;
        i_MemtoReg = !is_store; i_RegWrite = 1; i_rd_waddr = rd;
    endtask

    task automatic test_reset();
        set_idle();
        i_rst = 1;
        step(); step();
        checks++;
        if (o_valid !== 0 || o_RegWrite !== 0 || o_err !== 0 || o_stall !== 0 || o_dmem_req !== 0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%b rw=%b err=%b stall=%b req=%b, expected all 0",
                     o_valid, o_RegWrite, o_err, o_stall, o_dmem_req);
        end
        checks++;
        if (o_wb_data !== 32'h0 || o_rd_waddr !== 5'd0) begin
            errors++;
            $display("FAIL reset_data: got wb=%h rd=%0d, expected 0", o_wb_data, o_rd_waddr);
        end
        i_rst = 0;
        step();
    endtask

    task automatic test_back_to_back();
        set_idle();
        i_valid = 1; i_result = 32'h55; i_RegWrite = 1; i_rd_waddr = 5'd3;
        exp_q.push_back('{wb: 32'h55, rd: 5'd3, rw: 1'b1, err: 1'b0, chk_wb: 1'b1});
        #1;
        checks++;
        if (o_stall !== 0) begin errors++; $display("FAIL alu_nostall: got %b expected 0", o_stall); end
        step();
        checks++;
        if (o_valid !== 1 || o_wb_data !== 32'h55) begin
            errors++; $display("FAIL alu_latency: got valid=%b wb=%h expected 1/00000055", o_valid, o_wb_data);
        end
        drive_mem(0, 32'h200, 4'b1111, 0, 32'h0, 5'd4);
        i_dmem_ready = 1;
        exp_q.push_back('{wb: 32'hCAFE_F00D, rd: 5'd4, rw: 1'b1, err: 1'b0, chk_wb: 1'b1});
        #1;
        checks++;
        if (o_stall !== 1 || o_dmem_req !== 1 || o_dmem_addr !== 32'h200 || o_dmem_wen !== 0) begin
            errors++; $display("FAIL ld_issue: got stall=%b req=%b addr=%h wen=%b expected 1/1/00000200/0",
                               o_stall, o_dmem_req, o_dmem_addr, o_dmem_wen);
        end
        step();
        i_dmem_ready = 0;
        #1;
        checks++;
        if (o_valid !== 0 || o_wb_data !== 32'h55 || o_stall !== 1 || o_dmem_req !== 0) begin
            errors++; $display("FAIL ld_hold: got valid=%b wb=%h stall=%b req=%b expected 0/00000055/1/0",
                               o_valid, o_wb_data, o_stall, o_dmem_req);
        end
        step();
        i_dmem_rvalid = 1; i_dmem_rdata = 32'hCAFE_F00D;
        #1;
        checks++;
        if (o_stall !== 0) begin errors++; $display("FAIL ld_release: got stall=%b expected 0", o_stall); end
        step();
        set_idle();
        checks++;
        if (o_valid !== 1 || o_wb_data !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL ld_word: got valid=%b wb=%h expected 1/cafef00d", o_valid, o_wb_data);
        end
    endtask

    task automatic test_load_byte();
        int stall_cycles = 0;
        drive_mem(0, 32'h1001, 4'b0010, 0, 32'h0, 5'd5);
        i_dmem_ready = 1;
        exp_q.push_back('{wb: 32'hFFFF_FF80, rd: 5'd5, rw: 1'b1, err: 1'b0, chk_wb: 1'b1});
        #1;
        if (o_stall === 1) stall_cycles++;
        checks++;
        if (o_dmem_req !== 1 || o_dmem_mask !== 4'b0010 || o_dmem_addr !== 32'h1000) begin
            errors++; $display("FAIL lb_issue: got req=%b mask=%b addr=%h expected 1/0010/00001000",
                               o_dmem_req, o_dmem_mask, o_dmem_addr);
        end
        step();
        i_dmem_ready = 0;
        #1;
        if (o_stall === 1) stall_cycles++;
        step();
        i_dmem_rvalid = 1; i_dmem_rdata = 32'h0000_8000;
        #1;
        if (o_stall === 1) stall_cycles++;
        checks++;
        if (stall_cycles != 2) begin
            errors++; $display("FAIL lb_stall_cycles: got %0d expected 2", stall_cycles);
        end
        step();
        set_idle();
        checks++;
        if (o_valid !== 1 || o_wb_data !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL lb_sext: got valid=%b wb=%h expected 1/ffffff80", o_valid, o_wb_data);
        end
    endtask

    task automatic test_load_half_delayed();
        drive_mem(0, 32'h2002, 4'b1100, 1, 32'h0, 5'd6);
        exp_q.push_back('{wb: 32'h0000_BEEF, rd: 5'd6, rw: 1'b1, err: 1'b0, chk_wb: 1'b1});
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                // Upstream inputs wander: only the captured copies may reach the bus.
                i_mem_addr = 32'hDEAD_0000; i_mask = 4'b0001; i_store_data = 32'hFFFF_FFFF;
            end
            i_dmem_ready = (k == 3);
            #1;
            checks++;
            if (o_dmem_req !== 1 || o_stall !== 1 || o_dmem_addr !== 32'h2000 || o_dmem_mask !== 4'b1100) begin
                errors++; $display("FAIL lh_req_stable[%0d]: got req=%b stall=%b addr=%h mask=%b expected 1/1/00002000/1100",
                                   k, o_dmem_req, o_stall, o_dmem_addr, o_dmem_mask);
            end
            step();
        end
        i_dmem_ready = 0;
        #1;
        checks++;
        if (o_dmem_req !== 0 || o_stall !== 1) begin
            errors++; $display("FAIL lh_wait: got req=%b stall=%b expected 0/1", o_dmem_req, o_stall);
        end
        step();
        i_dmem_rvalid = 1; i_dmem_rdata = 32'hBEEF_0000;
        step();
        set_idle();
        checks++;
        if (o_valid !== 1 || o_wb_data !== 32'h0000_BEEF) begin
            errors++; $display("FAIL lh_zext: got valid=%b wb=%h expected 1/0000beef", o_valid, o_wb_data);
        end
    endtask

    task automatic test_store_byte();
        drive_mem(1, 32'h3002, 4'b0100, 0, 32'h1234_56AB, 5'd7);
        i_dmem_ready = 1;
        exp_q.push_back('{wb: 32'h3002, rd: 5'd7, rw: 1'b0, err: 1'b0, chk_wb: 1'b1});
        #1;
        checks++;
        if (o_dmem_wdata !== 32'hABAB_ABAB || o_dmem_wen !== 1 || o_dmem_mask !== 4'b0100 || o_dmem_req !== 1) begin
            errors++; $display("FAIL sb_lanes: got wdata=%h wen=%b mask=%b req=%b expected ababab ab/1/0100/1",
                               o_dmem_wdata, o_dmem_wen, o_dmem_mask, o_dmem_req);
        end
        step();
        i_dmem_ready = 0; i_dmem_rvalid = 1;
        step();
        set_idle();
        checks++;
        if (o_valid !== 1 || o_RegWrite !== 0) begin
            errors++; $display("FAIL sb_complete: got valid=%b rw=%b expected 1/0", o_valid, o_RegWrite);
        end
    endtask

    task automatic test_load_lanes();
        logic [3:0]  m;
        logic        u;
        logic [31:0] rdat;
        logic [31:0] ex;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin m = 4'b0001; u = 0; rdat = 32'h0000_00F0; ex = 32'hFFFF_FFF0; end
                1: begin m = 4'b1000; u = 1; rdat = 32'h8500_0000; ex = 32'h0000_0085; end
                2: begin m = 4'b0011; u = 0; rdat = 32'h1234_8001; ex = 32'hFFFF_8001; end
                default: begin m = 4'b1111; u = 0; rdat = 32'h8765_4321; ex = 32'h8765_4321; end
            endcase
            drive_mem(0, 32'h100, m, u, 32'h0, 5'(8 + k));
            i_dmem_ready = 1; i_dmem_rvalid = 0;
            exp_q.push_back('{wb: ex, rd: 5'(8 + k), rw: 1'b1, err: 1'b0, chk_wb: 1'b1});
            step();
            i_dmem_ready = 0; i_dmem_rvalid = 1; i_dmem_rdata = rdat;
            step();
        end
        set_idle();
        step();
    endtask

    task automatic test_store_lanes();
        logic [3:0]  m;
        logic [31:0] ex;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin m = 4'b0011; ex = 32'hBEEF_BEEF; end
                1: begin m = 4'b1111; ex = 32'hDEAD_BEEF; end
                default: begin m = 4'b1000; ex = 32'hEFEF_EFEF; end
            endcase
            drive_mem(1, 32'h400, m, 0, 32'hDEAD_BEEF, 5'd12);
            i_dmem_ready = 1; i_dmem_rvalid = 0;
            exp_q.push_back('{wb: 32'h400, rd: 5'd12, rw: 1'b0, err: 1'b0, chk_wb: 1'b1});
            #1;
            checks++;
            if (o_dmem_wdata !== ex || o_dmem_wen !== 1) begin
                errors++; $display("FAIL st_lanes[%0d]: got wdata=%h wen=%b expected %h/1", k, o_dmem_wdata, o_dmem_wen, ex);
            end
            step();
            i_dmem_ready = 0; i_dmem_rvalid = 1;
            step();
        end
        set_idle();
        step();
    endtask

    task automatic test_illegal_mask();
        drive_mem(0, 32'h6000, 4'b0101, 0, 32'h0, 5'd10);
        i_dmem_ready = 1;
        exp_q.push_back('{wb: 32'h0, rd: 5'd10, rw: 1'b0, err: 1'b1, chk_wb: 1'b0});
        #1;
        checks++;
        if (o_dmem_req !== 0 || o_stall !== 0) begin
            errors++; $display("FAIL ill_noreq: got req=%b stall=%b expected 0/0", o_dmem_req, o_stall);
        end
        step();
        checks++;
        if (o_valid !== 1 || o_err !== 1 || o_RegWrite !== 0) begin
            errors++; $display("FAIL ill_complete: got valid=%b err=%b rw=%b expected 1/1/0", o_valid, o_err, o_RegWrite);
        end
        // Misaligned word access.
        drive_mem(0, 32'h6003, 4'b1111, 0, 32'h0, 5'd11);
        i_dmem_ready = 1;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        exp_q.push_back('{wb: 32'h0, rd: 5'd11, rw: 1'b0, err: 1'b1, chk_wb: 1'b0});
        #1;
        checks++;
        if (o_dmem_req !== 0) begin errors++; $display("FAIL misalign_trap: got req=%b expected 0", o_dmem_req); end
        step();
`else
        exp_q.push_back('{wb: 32'h1122_3344, rd: 5'd11, rw: 1'b1, err: 1'b0, chk_wb: 1'b1});
        #1;
        checks++;
        if (o_dmem_req !== 1 || o_dmem_addr !== 32'h6000) begin
            errors++; $display("FAIL misalign_word: got req=%b addr=%h expected 1/00006000", o_dmem_req, o_dmem_addr);
        end
        step();
        i_dmem_ready = 0; i_dmem_rvalid = 1; i_dmem_rdata = 32'h1122_3344;
        step();
`endif
        set_idle();
        step();
    endtask

    task automatic test_timeout();
        drive_mem(0, 32'h5000, 4'b1111, 0, 32'h0, 5'd9);
        i_dmem_ready = 1;
        exp_q.push_back('{wb: 32'h0, rd: 5'd9, rw: 1'b0, err: 1'b1, chk_wb: 1'b1});
        step();
        i_dmem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (o_stall !== 1 || o_valid !== 0) begin
                errors++; $display("FAIL to_wait[%0d]: got stall=%b valid=%b expected 1/0", k, o_stall, o_valid);
            end
            step();
        end
        #1;
        checks++;
        if (o_stall !== 0) begin errors++; $display("FAIL to_release: got stall=%b expected 0", o_stall); end
        step();
        set_idle();
        checks++;
        if (o_valid !== 1 || o_err !== 1 || o_wb_data !== 32'h0) begin
            errors++; $display("FAIL to_complete: got valid=%b err=%b wb=%h expected 1/1/00000000", o_valid, o_err, o_wb_data);
        end
        i_dmem_rvalid = 1; i_dmem_rdata = 32'hFFFF_FFFF;
        step();
        i_dmem_rvalid = 0;
        checks++;
        if (o_valid !== 0) begin errors++; $display("FAIL to_late_rvalid: got valid=%b expected 0", o_valid); end
    endtask

    task automatic test_reset_mid_wait();
        drive_mem(0, 32'h7000, 4'b1111, 0, 32'h0, 5'd13);
        i_dmem_ready = 1;
        step();
        i_dmem_ready = 0;
        i_rst = 1;
        step();
        i_rst = 0;
        set_idle();
        #1;
        checks++;
        if (o_stall !== 0 || o_valid !== 0 || o_dmem_req !== 0) begin
            errors++; $display("FAIL rst_wait: got stall=%b valid=%b req=%b expected 0/0/0", o_stall, o_valid, o_dmem_req);
        end
        i_dmem_rvalid = 1; i_dmem_rdata = 32'h1234_5678;
        step();
        i_dmem_rvalid = 0;
        checks++;
        if (o_valid !== 0) begin errors++; $display("FAIL rst_late_rvalid: got valid=%b expected 0", o_valid); end
        step();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_byte();
        test_load_half_delayed();
        test_store_byte();
        test_load_lanes();
        test_store_lanes();
        test_illegal_mask();
        test_timeout();
        test_reset_mid_wait();
        step(); step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_drain: got %0d pending completions expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
